// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Brief    : Round-robin sequencer of one unified RAM between instruction  |
// |            fetch and load/store ports; RV32 byte masks, store data       |
// |            replication, load alignment/extension, misalignment errors.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iReady,
  output logic [31:0]       iRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [2:0]        dFunct3,
  input  logic [31:0]       dWdata,
  output logic              dReady,
  output logic [31:0]       dRdata,
  output logic              dError,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memWriteData,
  output logic              memWrite,
  output logic [3:0]        byteMask,
  input  logic [31:0]       memReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam int   CNT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  state_t              state_q, state_d;
  logic                lastGrant_q, lastGrant_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          alow_q, alow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                iReady_q, iReady_d;
  logic [31:0]         iRdata_q, iRdata_d;
  logic                dReady_q, dReady_d;
  logic [31:0]         dRdata_q, dRdata_d;
  logic                dError_q, dError_d;
  logic [ADDR_W-1:0]   memAddress_q, memAddress_d;
  logic [31:0]         memWriteData_q, memWriteData_d;
  logic                memWrite_q, memWrite_d;
  logic [3:0]          byteMask_q, byteMask_d;

  logic                w_grant;
  logic                w_dErr;
  logic [3:0]          w_stMask;
  logic [31:0]         w_stData;
  logic [7:0]          w_ldByte;
  logic [15:0]         w_ldHalf;
  logic [31:0]         w_ldData;
  logic                unused_iAddrLow;

  // Fetches are always word reads; the low address bits carry no meaning.
  assign unused_iAddrLow = ^iAddr[1:0];

  // Classify the pending data request: misaligned or illegal funct3 is an error.
  always_comb begin
    w_dErr = 1'b0;
    case (dFunct3)
      3'b000:         w_dErr = 1'b0;
      3'b001:         w_dErr = dAddr[0];
      3'b010:         w_dErr = |dAddr[1:0];
      3'b100, 3'b101: w_dErr = dWe | (dFunct3[0] & dAddr[0]);
      default:        w_dErr = 1'b1;
    endcase
  end

  // Store byte enables and lane-replicated write data from funct3 and address.
  always_comb begin
    w_stMask = 4'b1111;
    w_stData = dWdata;
    case (dFunct3[1:0])
      2'b00: begin
        w_stMask = 4'b0001 << dAddr[1:0];
        w_stData = {4{dWdata[7:0]}};
      end
      2'b01: begin
        w_stMask = 4'b0011 << {dAddr[1], 1'b0};
        w_stData = {2{dWdata[15:0]}};
      end
      default: begin
        w_stMask = 4'b1111;
        w_stData = dWdata;
      end
    endcase
  end

  // Pick the addressed byte/half of the RAM word and extend it by load type.
  always_comb begin
    w_ldByte = memReadData[{alow_q, 3'b000} +: 8];
    w_ldHalf = alow_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3_q)
      3'b000:  w_ldData = {{24{w_ldByte[7]}}, w_ldByte};
      3'b001:  w_ldData = {{16{w_ldHalf[15]}}, w_ldHalf};
      3'b100:  w_ldData = {24'h0, w_ldByte};
      3'b101:  w_ldData = {16'h0, w_ldHalf};
      default: w_ldData = memReadData;
    endcase
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d        = state_q;
    lastGrant_d    = lastGrant_q;
    grant_d        = grant_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    alow_d         = alow_q;
    cnt_d          = cnt_q;
    iReady_d       = iReady_q;
    iRdata_d       = iRdata_q;
    dReady_d       = dReady_q;
    dRdata_d       = dRdata_q;
    dError_d       = dError_q;
    memAddress_d   = memAddress_q;
    memWriteData_d = memWriteData_q;
    memWrite_d     = memWrite_q;
    byteMask_d     = byteMask_q;
    // On a tie the port that did not win last time goes next.
    w_grant        = dReq & (~iReq | (lastGrant_q == GRANT_I));

    case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          lastGrant_d = w_grant;
          grant_d     = w_grant;
          cnt_d       = '0;
          if (w_grant == GRANT_D) begin
            we_d     = dWe;
            funct3_d = dFunct3;
            alow_d   = dAddr[1:0];
            if (w_dErr) begin
              // Faulting requests answer immediately and never reach the RAM.
              state_d  = RESP;
              dReady_d = 1'b1;
              dError_d = 1'b1;
              dRdata_d = 32'h0;
            end else begin
              state_d      = ACCESS;
              memAddress_d = {dAddr[ADDR_W-1:2], 2'b00};
              if (dWe) begin
                memWrite_d     = 1'b1;
                byteMask_d     = w_stMask;
                memWriteData_d = w_stData;
              end else begin
                memWrite_d = 1'b0;
                byteMask_d = 4'b1111;
              end
            end
          end else begin
            we_d         = 1'b0;
            state_d      = ACCESS;
            memAddress_d = {iAddr[ADDR_W-1:2], 2'b00};
            memWrite_d   = 1'b0;
            byteMask_d   = 4'b1111;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d    = RESP;
          memWrite_d = 1'b0;
          byteMask_d = 4'b0000;
          dReady_d   = 1'b1;
          dError_d   = 1'b0;
          dRdata_d   = 32'h0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          byteMask_d = 4'b0000;
          if (grant_q == GRANT_D) begin
            dReady_d = 1'b1;
            dError_d = 1'b0;
            dRdata_d = w_ldData;
          end else begin
            iReady_d = 1'b1;
            iRdata_d = memReadData;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d    = IDLE;
        iReady_d   = 1'b0;
        iRdata_d   = 32'h0;
        dReady_d   = 1'b0;
        dRdata_d   = 32'h0;
        dError_d   = 1'b0;
        memWrite_d = 1'b0;
        byteMask_d = 4'b0000;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      lastGrant_q    <= GRANT_I;
      grant_q        <= GRANT_I;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      alow_q         <= 2'b00;
      cnt_q          <= '0;
      iReady_q       <= 1'b0;
      iRdata_q       <= 32'h0;
      dReady_q       <= 1'b0;
      dRdata_q       <= 32'h0;
      dError_q       <= 1'b0;
      memAddress_q   <= '0;
      memWriteData_q <= 32'h0;
      memWrite_q     <= 1'b0;
      byteMask_q     <= 4'b0000;
    end else begin
      state_q        <= state_d;
      lastGrant_q    <= lastGrant_d;
      grant_q        <= grant_d;
      we_q           <= we_d;
      funct3_q       <= funct3_d;
      alow_q         <= alow_d;
      cnt_q          <= cnt_d;
      iReady_q       <= iReady_d;
      iRdata_q       <= iRdata_d;
      dReady_q       <= dReady_d;
      dRdata_q       <= dRdata_d;
      dError_q       <= dError_d;
      memAddress_q   <= memAddress_d;
      memWriteData_q <= memWriteData_d;
      memWrite_q     <= memWrite_d;
      byteMask_q     <= byteMask_d;
    end
  end

  assign iReady       = iReady_q;
  assign iRdata       = iRdata_q;
  assign dReady       = dReady_q;
  assign dRdata       = dRdata_q;
  assign dError       = dError_q;
  assign memAddress   = memAddress_q;
  assign memWriteData = memWriteData_q;
  assign memWrite     = memWrite_q;
  assign byteMask     = byteMask_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared unified RAM between the instruction-fetch port and the load/store port of the multicycle core.
- Round-robin arbitration between the two ports.
- Generates word-aligned addresses, byte masks and replicated write data from RV32 funct3.
- Aligns and sign-extends load data.
- Flags misaligned and illegal accesses without touching RAM.

Parameters:
- ADDR_W, 32, address width of both request ports and memAddress.
- RD_LATENCY, 1, cycles from memAddress stable to memReadData valid (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- iReq  in  1  fetch request; held until iReady.
- iAddr  in  ADDR_W  fetch address; bits [1:0] ignored.
- iReady  out  1  one-cycle completion pulse.
- iRdata  out  32  fetched word; valid while iReady=1.
- dReq  in  1  load/store request; held with its fields until dReady.
- dWe  in  1  1=store, 0=load.
- dAddr  in  ADDR_W  byte address.
- dFunct3  in  3  RV32 load/store funct3.
- dWdata  in  32  store data; low bytes used for SB/SH.
- dReady  out  1  one-cycle completion pulse.
- dRdata  out  32  extended load data; valid while dReady=1, 0 for stores and errors.
- dError  out  1  with dReady: misaligned or illegal funct3.
- memAddress  out  ADDR_W  RAM address, always {addr[ADDR_W-1:2],2'b00}.
- memWriteData  out  32  RAM write data.
- memWrite  out  1  RAM write strobe.
- byteMask  out  4  RAM byte enables.
- memReadData  in  32  RAM read data.

Behaviour:
- All outputs registered.
- Reset values: every output 0; state=IDLE; lastGrant=I.
- FSM states:
  - IDLE: sample requests. None → stay. Otherwise grant and go to ACCESS, or to RESP if the data request is an error.
  - ACCESS: drives RAM. Store: memWrite=1 for exactly one cycle, then RESP. Load/fetch: hold address RD_LATENCY cycles (counter), capture memReadData on the last, then RESP.
  - RESP: pulse iReady or dReady (by grant) for one cycle with data/error, clear memWrite and byteMask, then IDLE.
- Arbitration (IDLE only):
  - Only one request → grant it.
  - Both requesting → grant the port opposite to lastGrant; lastGrant updates on every grant.
  - First tie after reset goes to D.
  - A port is never granted twice in a row while the other is requesting.
- Latency with RD_LATENCY=1, request first seen in IDLE at cycle 0:
  - Read: ready at cycle 2.
  - Store: memWrite at cycle 1, ready at cycle 2.
  - Error: ready at cycle 1.
  - Next request sampled in IDLE at cycle 3; the requester deasserts or changes its request on the ready edge.
- Byte mask and write data (stores):
  - funct3=000 (SB): mask 4'b0001<<addr[1:0]; data {4{dWdata[7:0]}}.
  - funct3=001 (SH): mask 4'b0011<<{addr[1],1'b0}; data {2{dWdata[15:0]}}.
  - funct3=010 (SW): mask 4'b1111; data dWdata.
- Reads and fetches drive byteMask=4'b1111 and memWrite=0.
- Loads: select the byte/half by addr[1:0] from the captured word.
  - 000 LB, 001 LH: sign-extend.
  - 100 LBU, 101 LHU: zero-extend.
  - 010 LW: full word.
- Errors, raised as dError=1, dRdata=0, with no RAM access and no memWrite:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
- A request dropped mid-service is ignored: the access completes and ready still pulses.
- Fields changing mid-service are ignored: latched at grant.
- Reset asserted in any state: next edge forces IDLE, memWrite=0, ready outputs 0, counter cleared.
  - An in-flight access is abandoned; no write is issued after reset.
- No combinational path from any input to any output.

Test Plan:
- Fetch only, RAM word 0x0000_0100=0xDEAD_BEEF, iAddr=0x102 → cycle 1: memAddress=0x100, byteMask=1111, memWrite=0; cycle 2: iReady=1, iRdata=0xDEADBEEF; dReady stays 0.
- SB dAddr=0x4002, dWdata=0x1234_5678 → cycle 1: memAddress=0x4000, byteMask=0100, memWriteData=0x7878_7878, memWrite=1 for one cycle; cycle 2: dReady=1, dError=0, dRdata=0.
- RAM 0x8000=0x80FF_7F01: LB@0x8003 → 0xFFFFFF80; LBU@0x8003 → 0x00000080; LH@0x8002 → 0xFFFF80FF; LHU@0x8000 → 0x00007F01; LW@0x8000 → 0x80FF7F01.
- Misaligned SW dAddr=0xC002 → dReady=1 with dError=1 at cycle 1, memWrite never 1; LH@0xC001 likewise; funct3=011 load likewise.
- iReq and dReq held continuously from reset → grants alternate D,I,D,I; each ready every 3 cycles, never two consecutive grants to one port.
- SW issued, reset asserted in cycle 1 (ACCESS) → the following edge has memWrite=0 and state IDLE; no dReady pulse; outputs all 0; after release, first tie goes to D.
